// File: rtl/hippo_mem_arbiter_if.sv
// Requester-side bus for hippo_mem_arbiter: one instance per requester.
//   master : driven by the requester (valid/addr/we/be/wdata out; ready/rsp in)
//   slave  : seen by the arbiter (valid/addr/we/be/wdata in; ready/rsp out)
// Signals:
//   valid      request valid
//   ready      request accepted this cycle
//   addr       word address
//   we         write
//   be         byte enables, bit n covers bits 8n+7:8n
//   wdata      write data
//   rsp_valid  response valid
//   rdata      read data (0 for write responses)
interface hippo_mem_arbiter_if #(
  parameter int AddrWidth = 8
);
  logic                 valid;
  logic                 ready;
  logic [AddrWidth-1:0] addr;
  logic                 we;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic                 rsp_valid;
  logic [31:0]          rdata;

  modport master (
    output valid, addr, we, be, wdata,
    input  ready, rsp_valid, rdata
  );

  modport slave (
    input  valid, addr, we, be, wdata,
    output ready, rsp_valid, rdata
  );
endinterface

// File: rtl/hippo_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory
// with a registered read port. Partial (byte-enabled) stores are turned
// into a read followed by a merged write.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   a, b            requester buses (a = instruction fetch, b = load/store)
//   mem_address_o   memory word address
//   mem_we_o        memory write enable
//   mem_data_o      memory write data
//   mem_data_i      memory read data, valid one cycle after its address
//
// state | meaning
// IDLE  | arbitrate; reads, full and null writes complete in one cycle
// RMW   | write back merged word of a partial store; both requesters stalled
module hippo_mem_arbiter #(
  parameter int AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hippo_mem_arbiter_if.slave   a,
  hippo_mem_arbiter_if.slave   b,
  output logic [AddrWidth-1:0] mem_address_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i
);

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // 1 = requester B was granted last, so A wins the next tie
  logic last_q;

  logic                 grant_a, grant_b, accept;
  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_we;
  logic [3:0]           sel_be;
  logic [31:0]          sel_wdata;
  logic                 is_full, is_partial;

  logic [AddrWidth-1:0] addr_hold_q;
  logic [AddrWidth-1:0] rmw_addr_q;
  logic [3:0]           rmw_be_q;
  logic [31:0]          rmw_wdata_q;
  logic                 rmw_id_q;

  logic rsp_valid_q, rsp_id_q, rsp_read_q;
  logic [31:0] merged;

  // Arbitration is only open in IDLE and never while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst_i && state_q == IDLE) begin
      if (a.valid && (!b.valid || last_q)) grant_a = 1'b1;
      else if (b.valid)                    grant_b = 1'b1;
    end
    accept     = grant_a | grant_b;
    sel_addr   = grant_b ? b.addr  : a.addr;
    sel_we     = grant_b ? b.we    : a.we;
    sel_be     = grant_b ? b.be    : a.be;
    sel_wdata  = grant_b ? b.wdata : a.wdata;
    is_full    = sel_we && (sel_be == 4'hF);
    is_partial = sel_we && (sel_be != 4'h0) && (sel_be != 4'hF);
  end

  always_comb begin
    merged = mem_data_i;
    for (int n = 0; n < 4; n++) begin
      if (rmw_be_q[n]) merged[8*n +: 8] = rmw_wdata_q[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_partial) state_d = RMW;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a.ready       = grant_a;
    b.ready       = grant_b;
    mem_address_o = '0;
    mem_we_o      = 1'b0;
    mem_data_o    = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          mem_address_o = accept ? sel_addr : addr_hold_q;
          mem_we_o      = accept && is_full;
          mem_data_o    = accept ? sel_wdata : 32'h0;
        end
        RMW: begin
          mem_address_o = rmw_addr_q;
          mem_we_o      = 1'b1;
          mem_data_o    = merged;
        end
        default: ;
      endcase
    end
    a.rsp_valid = !rst_i && rsp_valid_q && !rsp_id_q;
    b.rsp_valid = !rst_i && rsp_valid_q &&  rsp_id_q;
    a.rdata     = (a.rsp_valid && rsp_read_q) ? mem_data_i : 32'h0;
    b.rdata     = (b.rsp_valid && rsp_read_q) ? mem_data_i : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= 1'b1;
      addr_hold_q <= '0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      rmw_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      // A partial store answers only after its write-back cycle.
      rsp_valid_q <= (accept && !is_partial) || (state_q == RMW);
      rsp_id_q    <= (state_q == RMW) ? rmw_id_q : grant_b;
      rsp_read_q  <= accept && !sel_we;
      if (accept) begin
        last_q      <= grant_b;
        addr_hold_q <= sel_addr;
        if (is_partial) begin
          rmw_addr_q  <= sel_addr;
          rmw_be_q    <= sel_be;
          rmw_wdata_q <= sel_wdata;
          rmw_id_q    <= grant_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Self-checking bench for hippo_mem_arbiter: a transaction-level model with
// its own copy of memory is compared on every cycle, and directed sequences
// pin literal values.
module tb_hippo_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_address;
  logic        mem_we;
  logic [31:0] mem_data;
  logic [31:0] mem_data_i;

  int checks = 0;
  int failures = 0;

  hippo_mem_arbiter_if #(.AddrWidth(8)) a_if ();
  hippo_mem_arbiter_if #(.AddrWidth(8)) b_if ();

  hippo_mem_arbiter #(.AddrWidth(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .a             (a_if),
    .b             (b_if),
    .mem_address_o (mem_address),
    .mem_we_o      (mem_we),
    .mem_data_o    (mem_data),
    .mem_data_i    (mem_data_i)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: registered read, single write port.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_data;
    mem_data_i <= mem[mem_address];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  logic [31:0] ref_mem [256];
  bit          m_rmw = 0;
  logic [7:0]  m_rmw_addr;
  logic [3:0]  m_rmw_be;
  logic [31:0] m_rmw_wdata;
  bit          m_rmw_b;
  bit          m_last_b = 1;
  logic [7:0]  m_hold = 8'h0;
  bit          rsp_v = 0;
  bit          rsp_b = 0;
  logic [31:0] rsp_d = 32'h0;

  always @(negedge clk) begin
    bit          e_ra, e_rb, e_we, n_v, n_b, pick_b, ea_rsp, eb_rsp;
    logic [7:0]  e_addr, r_addr;
    logic [31:0] e_data, n_d, r_wdata, old;
    logic        r_we;
    logic [3:0]  r_be;
    e_ra = 0; e_rb = 0; e_we = 0; e_addr = 8'h0; e_data = 32'h0;
    n_v = 0; n_b = 0; n_d = 32'h0;
    if (rst) begin
      m_rmw = 0;
      m_last_b = 1;
      m_hold = 8'h0;
    end else if (m_rmw) begin
      old = ref_mem[m_rmw_addr];
      for (int n = 0; n < 4; n++)
        e_data[8*n +: 8] = m_rmw_be[n] ? m_rmw_wdata[8*n +: 8] : old[8*n +: 8];
      ref_mem[m_rmw_addr] = e_data;
      e_we = 1;
      e_addr = m_rmw_addr;
      n_v = 1;
      n_b = m_rmw_b;
      m_rmw = 0;
    end else if (a_if.valid || b_if.valid) begin
      // the requester not served last wins a tie
      pick_b = (a_if.valid && b_if.valid) ? !m_last_b : b_if.valid;
      r_addr  = pick_b ? b_if.addr  : a_if.addr;
      r_we    = pick_b ? b_if.we    : a_if.we;
      r_be    = pick_b ? b_if.be    : a_if.be;
      r_wdata = pick_b ? b_if.wdata : a_if.wdata;
      e_ra = !pick_b;
      e_rb = pick_b;
      e_addr = r_addr;
      m_hold = r_addr;
      m_last_b = pick_b;
      if (!r_we) begin
        n_v = 1; n_b = pick_b; n_d = ref_mem[r_addr];
      end else if (r_be == 4'hF) begin
        e_we = 1; e_data = r_wdata; ref_mem[r_addr] = r_wdata;
        n_v = 1; n_b = pick_b;
      end else if (r_be == 4'h0) begin
        n_v = 1; n_b = pick_b;
      end else begin
        m_rmw = 1; m_rmw_addr = r_addr; m_rmw_be = r_be;
        m_rmw_wdata = r_wdata; m_rmw_b = pick_b;
      end
    end else begin
      e_addr = m_hold;
    end
    ea_rsp = !rst && rsp_v && !rsp_b;
    eb_rsp = !rst && rsp_v && rsp_b;
    check("model_a_ready", 32'(a_if.ready), 32'(e_ra));
    check("model_b_ready", 32'(b_if.ready), 32'(e_rb));
    check("model_mem_we", 32'(mem_we), 32'(e_we));
    check("model_mem_addr", 32'(mem_address), 32'(e_addr));
    if (e_we || rst) check("model_mem_data", mem_data, e_data);
    check("model_a_rsp_valid", 32'(a_if.rsp_valid), 32'(ea_rsp));
    check("model_b_rsp_valid", 32'(b_if.rsp_valid), 32'(eb_rsp));
    check("model_a_rdata", a_if.rdata, ea_rsp ? rsp_d : 32'h0);
    check("model_b_rdata", b_if.rdata, eb_rsp ? rsp_d : 32'h0);
    rsp_v = n_v; rsp_b = n_b; rsp_d = n_d;
  end

  // ---------------- directed stimulus ----------------
  task automatic set_a(input logic v, input logic [7:0] ad, input logic w,
                       input logic [3:0] be, input logic [31:0] d);
    a_if.valid = v; a_if.addr = ad; a_if.we = w; a_if.be = be; a_if.wdata = d;
  endtask

  task automatic set_b(input logic v, input logic [7:0] ad, input logic w,
                       input logic [3:0] be, input logic [31:0] d);
    b_if.valid = v; b_if.addr = ad; b_if.we = w; b_if.be = be; b_if.wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[3] <= 32'hDEADBEEF;  ref_mem[3] = 32'hDEADBEEF;
    mem[5] <= 32'h11223344;  ref_mem[5] = 32'h11223344;
    mem[9] <= 32'h55667788;  ref_mem[9] = 32'h55667788;

    // reset held with both requesters asking
    rst = 1'b1;
    set_a(1, 8'd3, 0, 4'h0, 32'h0);
    set_b(1, 8'd5, 0, 4'h0, 32'h0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_a_ready", 32'(a_if.ready), 32'h0);
      check("rst_b_ready", 32'(b_if.ready), 32'h0);
      check("rst_rsp_valid", 32'({a_if.rsp_valid, b_if.rsp_valid}), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      next_cycle();
    end
    rst = 1'b0;
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    set_b(0, 8'd0, 0, 4'h0, 32'h0);
    next_cycle();

    // both reading continuously: A,B,A,B,A,B
    set_a(1, 8'd3, 0, 4'h0, 32'h0);
    set_b(1, 8'd5, 0, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_a_ready", 32'(a_if.ready), 32'(i % 2 == 0));
      check("rr_b_ready", 32'(b_if.ready), 32'(i % 2 == 1));
      check("rr_a_rsp", 32'(a_if.rsp_valid), 32'(i % 2 == 1));
      check("rr_b_rsp", 32'(b_if.rsp_valid), 32'(i > 0 && i % 2 == 0));
      if (i % 2 == 1) check("rr_a_rdata", a_if.rdata, 32'hDEADBEEF);
      next_cycle();
    end
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    set_b(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("rr_last_b_rsp", 32'(b_if.rsp_valid), 32'h1);
    check("rr_last_b_rdata", b_if.rdata, 32'h11223344);
    next_cycle();

    // single read by A
    set_a(1, 8'd3, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("rd_a_ready", 32'(a_if.ready), 32'h1);
    next_cycle();
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("rd_a_rsp", 32'(a_if.rsp_valid), 32'h1);
    check("rd_a_rdata", a_if.rdata, 32'hDEADBEEF);
    check("rd_b_rsp", 32'(b_if.rsp_valid), 32'h0);
    next_cycle();

    // partial write by B while A waits (last grant was A, so B wins)
    set_a(1, 8'd3, 0, 4'h0, 32'h0);
    set_b(1, 8'd5, 1, 4'b0101, 32'hAABBCCDD);
    @(negedge clk);
    check("pw_b_ready", 32'(b_if.ready), 32'h1);
    check("pw_a_ready_t", 32'(a_if.ready), 32'h0);
    check("pw_we_t", 32'(mem_we), 32'h0);
    next_cycle();
    set_b(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("pw_a_ready_t1", 32'(a_if.ready), 32'h0);
    check("pw_we_t1", 32'(mem_we), 32'h1);
    check("pw_addr_t1", 32'(mem_address), 32'h5);
    check("pw_data_t1", mem_data, 32'h11BB33DD);
    next_cycle();
    @(negedge clk);
    check("pw_a_ready_t2", 32'(a_if.ready), 32'h1);
    check("pw_b_rsp_t2", 32'(b_if.rsp_valid), 32'h1);
    check("pw_b_rdata_t2", b_if.rdata, 32'h0);
    next_cycle();
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("pw_a_rdata", a_if.rdata, 32'hDEADBEEF);
    next_cycle();

    // full write, read back, null write, read back
    set_a(1, 8'd7, 1, 4'hF, 32'h0000CAFE);
    @(negedge clk);
    check("fw_we", 32'(mem_we), 32'h1);
    check("fw_data", mem_data, 32'h0000CAFE);
    next_cycle();
    set_a(1, 8'd7, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("fw_rsp", 32'(a_if.rsp_valid), 32'h1);
    check("fw_rsp_rdata", a_if.rdata, 32'h0);
    next_cycle();
    set_a(1, 8'd7, 1, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    check("fw_readback", a_if.rdata, 32'h0000CAFE);
    check("nw_we", 32'(mem_we), 32'h0);
    next_cycle();
    set_a(1, 8'd7, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("nw_rsp", 32'(a_if.rsp_valid), 32'h1);
    next_cycle();
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("nw_readback", a_if.rdata, 32'h0000CAFE);
    next_cycle();

    // reset landing on the write-back cycle of a partial store
    set_b(1, 8'd9, 1, 4'b0011, 32'h0);
    @(negedge clk);
    check("rr_pw_b_ready", 32'(b_if.ready), 32'h1);
    next_cycle();
    set_b(0, 8'd0, 0, 4'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rr_pw_we", 32'(mem_we), 32'h0);
    check("rr_pw_b_rsp_rst", 32'(b_if.rsp_valid), 32'h0);
    next_cycle();
    rst = 1'b0;
    set_a(1, 8'd9, 0, 4'h0, 32'h0);
    set_b(1, 8'd3, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("rr_pw_b_rsp_after", 32'(b_if.rsp_valid), 32'h0);
    check("rr_tie_a_ready", 32'(a_if.ready), 32'h1);
    check("rr_tie_b_ready", 32'(b_if.ready), 32'h0);
    next_cycle();
    set_a(0, 8'd0, 0, 4'h0, 32'h0);
    set_b(0, 8'd0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("rr_word_unchanged", a_if.rdata, 32'h55667788);
    next_cycle();
    next_cycle();

    check("mem5_final", mem[5], 32'h11BB33DD);
    check("mem7_final", mem[7], 32'h0000CAFE);
    check("mem9_final", mem[9], 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
